// File: rtl/up_counter_timer_if.sv
// Control/status bundle for up_counter_timer: the master drives commands and
// values, the slave (the timer) returns count and flags.
interface up_counter_timer_if #(
    parameter int unsigned W = 4
);
    logic         load;
    logic [W-1:0] din;
    logic [W-1:0] limit;
    logic         start;
    logic         stop;
    logic         auto_reload;
    logic         ovf_clr;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
    logic         ovf;

    modport master (
        output load, din, limit, start, stop, auto_reload, ovf_clr,
        input  count, tc, busy, ovf
    );

    modport slave (
        input  load, din, limit, start, stop, auto_reload, ovf_clr,
        output count, tc, busy, ovf
    );
endinterface

// File: rtl/up_counter_timer.sv
// Loadable up-counting timer with one-shot / auto-reload modes and sticky wrap flag.
// Optional tick prescaler enabled by defining PRESCALE_EN.
module up_counter_timer #(
    parameter int unsigned W        = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    up_counter_timer_if.slave bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t       state_r;
    logic [W-1:0] count_r;
    logic [W-1:0] rld_r;
    logic         tc_r;
    logic         busy_r;
    logic         ovf_r;
    logic         presc_hit_s;
    logic         tick_s;
    logic         term_s;
    logic         wrap_s;

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("PRESCALE must be at least 1");
    end

`ifdef PRESCALE_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] presc_r;

    // Prescaler: free-runs in RUN, restarts on any event that re-phases the count.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            presc_r <= {PW{1'b0}};
        end else if (bus.load || bus.stop || (bus.start && (state_r == IDLE)) || term_s) begin
            presc_r <= {PW{1'b0}};
        end else if (state_r == RUN) begin
            if (presc_hit_s) begin
                presc_r <= {PW{1'b0}};
            end else begin
                presc_r <= presc_r + PW'(1);
            end
        end else begin
            presc_r <= presc_r;
        end
    end

    // Tick strobe when the prescaler completes a period.
    always_comb begin
        presc_hit_s = (presc_r == PW'(PRESCALE - 1));
    end
`else
    // Without a prescaler every RUN clock is a tick.
    always_comb begin
        presc_hit_s = 1'b1;
    end
`endif

    // Load and stop outrank the tick, so either one suppresses it.
    always_comb begin
        tick_s = (state_r == RUN) && !bus.load && !bus.stop && presc_hit_s;
        term_s = tick_s && (count_r == bus.limit);
        wrap_s = tick_s && !term_s && (count_r == {W{1'b1}});
    end

    // Timer FSM, counter, reload register and registered flags.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            count_r <= {W{1'b0}};
            rld_r   <= {W{1'b0}};
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            tc_r <= term_s;

            if (bus.stop) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
            end else if (bus.start) begin
                state_r <= RUN;
                busy_r  <= 1'b1;
            end else if (term_s && !bus.auto_reload) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
            end else begin
                state_r <= state_r;
                busy_r  <= busy_r;
            end

            if (bus.load) begin
                count_r <= bus.din;
                rld_r   <= bus.din;
            end else if (term_s) begin
                count_r <= rld_r;
                rld_r   <= rld_r;
            end else if (tick_s) begin
                count_r <= count_r + W'(1);
                rld_r   <= rld_r;
            end else begin
                count_r <= count_r;
                rld_r   <= rld_r;
            end

            // A wrap on the same edge as ovf_clr keeps the flag set.
            if (wrap_s) begin
                ovf_r <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign bus.count = count_r;
    assign bus.tc    = tc_r;
    assign bus.busy  = busy_r;
    assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_up_counter_timer.sv
// Directed self-checking bench for up_counter_timer (W=4); the prescaled
// scenario runs when PRESCALE_EN is defined.
module tb_up_counter_timer;
    logic clk;
    logic clr_n;
    int   checks;
    int   failures;

    up_counter_timer_if #(.W(4)) bus ();

    up_counter_timer #(.W(4), .PRESCALE(4)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int b, input int t, input int o);
        chk({tag, ".count"}, 32'(bus.count), 32'(c));
        chk({tag, ".busy"},  32'(bus.busy),  32'(b));
        chk({tag, ".tc"},    32'(bus.tc),    32'(t));
        chk({tag, ".ovf"},   32'(bus.ovf),   32'(o));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clr_n    = 1'b0;
        bus.load = 1'b1; bus.din = 4'd5; bus.limit = 4'd6;
        bus.start = 1'b1; bus.stop = 1'b0; bus.auto_reload = 1'b0; bus.ovf_clr = 1'b0;
        #2;
        step();
        chk_all("reset", 0, 0, 0, 0);
        clr_n = 1'b1; bus.load = 1'b0; bus.start = 1'b0;

`ifdef PRESCALE_EN
        bus.load = 1'b1; bus.din = 4'd0; bus.limit = 4'd2; bus.start = 1'b1;
        bus.auto_reload = 1'b0;
        step();
        chk_all("ps.start", 0, 1, 0, 0);
        bus.load = 1'b0; bus.start = 1'b0;
        step(); step(); step();
        chk_all("ps.hold0", 0, 1, 0, 0);
        step();
        chk_all("ps.c1", 1, 1, 0, 0);
        step(); step(); step();
        chk_all("ps.hold1", 1, 1, 0, 0);
        step();
        chk_all("ps.c2", 2, 1, 0, 0);
        step(); step(); step(); step();
        chk_all("ps.term", 0, 0, 1, 0);
        step();
        chk_all("ps.after", 0, 0, 0, 0);
`else
        // One-shot 3..6
        bus.load = 1'b1; bus.din = 4'd3; bus.limit = 4'd6; bus.start = 1'b1;
        bus.auto_reload = 1'b0;
        step();
        chk_all("os.load", 3, 1, 0, 0);
        bus.load = 1'b0; bus.start = 1'b0;
        step(); chk_all("os.c4", 4, 1, 0, 0);
        step(); chk_all("os.c5", 5, 1, 0, 0);
        step(); chk_all("os.c6", 6, 1, 0, 0);
        step(); chk_all("os.term", 3, 0, 1, 0);
        step(); chk_all("os.idle", 3, 0, 0, 0);

        // Auto-reload with wrap: 13,14,15,0,1,2,13
        bus.load = 1'b1; bus.din = 4'd13; bus.limit = 4'd2; bus.start = 1'b1;
        bus.auto_reload = 1'b1;
        step(); chk_all("ar.load", 13, 1, 0, 0);
        bus.load = 1'b0; bus.start = 1'b0;
        step(); chk_all("ar.c14", 14, 1, 0, 0);
        step(); chk_all("ar.c15", 15, 1, 0, 0);
        step(); chk_all("ar.wrap", 0, 1, 0, 1);
        step(); chk_all("ar.c1", 1, 1, 0, 1);
        step(); chk_all("ar.c2", 2, 1, 0, 1);
        step(); chk_all("ar.term", 13, 1, 1, 1);
        step(); chk_all("ar.c14b", 14, 1, 0, 1);
        bus.ovf_clr = 1'b1;
        step(); chk_all("ar.ovfclr", 15, 1, 0, 0);
        step(); chk_all("ar.setwins", 0, 1, 0, 1);
        bus.ovf_clr = 1'b0;

        // Stop / start interplay
        bus.load = 1'b1; bus.din = 4'd4; bus.limit = 4'd15; bus.start = 1'b1;
        bus.auto_reload = 1'b0;
        step(); chk_all("ss.load", 4, 1, 0, 1);
        bus.load = 1'b0; bus.start = 1'b0;
        step(); chk_all("ss.c5", 5, 1, 0, 1);
        bus.stop = 1'b1;
        step(); chk_all("ss.stop", 5, 0, 0, 1);
        bus.start = 1'b1;
        step(); chk_all("ss.both", 5, 0, 0, 1);
        bus.stop = 1'b0;
        step(); chk_all("ss.start", 5, 1, 0, 1);
        bus.start = 1'b0;
        step(); chk_all("ss.c6", 6, 1, 0, 1);

        // Reset aborts RUN
        bus.load = 1'b1; bus.din = 4'd3; bus.start = 1'b1;
        step(); bus.load = 1'b0; bus.start = 1'b0;
        step(); chk_all("rs.c4", 4, 1, 0, 1);
        clr_n = 1'b0;
        step(); chk_all("rs.reset", 0, 0, 0, 0);
        clr_n = 1'b1;
        step(); chk_all("rs.idle", 0, 0, 0, 0);

        // Load while running
        bus.load = 1'b1; bus.din = 4'd0; bus.start = 1'b1;
        step(); bus.load = 1'b0; bus.start = 1'b0;
        step(); chk_all("lr.c1", 1, 1, 0, 0);
        bus.load = 1'b1; bus.din = 4'd9;
        step(); chk_all("lr.load9", 9, 1, 0, 0);
        bus.load = 1'b0;
        step(); chk_all("lr.c10", 10, 1, 0, 0);

        // Stop on the terminal tick suppresses it
        bus.load = 1'b1; bus.din = 4'd7; bus.limit = 4'd8; bus.start = 1'b1;
        step(); bus.load = 1'b0; bus.start = 1'b0;
        step(); chk_all("st.c8", 8, 1, 0, 0);
        bus.stop = 1'b1;
        step(); chk_all("st.stopterm", 8, 0, 0, 0);
        bus.stop = 1'b0;

        // rld == limit under auto-reload: tc every tick
        bus.load = 1'b1; bus.din = 4'd5; bus.limit = 4'd5; bus.start = 1'b1;
        bus.auto_reload = 1'b1;
        step(); chk_all("eq.load", 5, 1, 0, 0);
        bus.load = 1'b0; bus.start = 1'b0;
        step(); chk_all("eq.tc1", 5, 1, 1, 0);
        step(); chk_all("eq.tc2", 5, 1, 1, 0);

        // Live limit: raising it mid-run extends the count
        bus.limit = 4'd7;
        step(); chk_all("lim.c6", 6, 1, 0, 0);
        step(); chk_all("lim.c7", 7, 1, 0, 0);
        step(); chk_all("lim.term", 5, 1, 1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
